// File: rtl/status_flags_unit_pkg.sv
// Shared constants for the NZCV status unit: ALU op codes, condition
// codes and the bit positions of each flag inside a packed NZCV nibble.
package status_flags_unit_pkg;

   localparam int NZCV_W = 4;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   localparam logic [3:0] COND_EQ = 4'd0;
   localparam logic [3:0] COND_NE = 4'd1;
   localparam logic [3:0] COND_CS = 4'd2;
   localparam logic [3:0] COND_CC = 4'd3;
   localparam logic [3:0] COND_MI = 4'd4;
   localparam logic [3:0] COND_PL = 4'd5;
   localparam logic [3:0] COND_VS = 4'd6;
   localparam logic [3:0] COND_VC = 4'd7;
   localparam logic [3:0] COND_HI = 4'd8;
   localparam logic [3:0] COND_LS = 4'd9;
   localparam logic [3:0] COND_GE = 4'd10;
   localparam logic [3:0] COND_LT = 4'd11;
   localparam logic [3:0] COND_GT = 4'd12;
   localparam logic [3:0] COND_LE = 4'd13;
   localparam logic [3:0] COND_AL = 4'd14;
   localparam logic [3:0] COND_NV = 4'd15;

endpackage

// File: rtl/status_flags_unit_if.sv
// Bundle of ALU-side inputs, control strobes and flag outputs of the
// status unit. The datapath drives through master, the unit sits on slave.
interface status_flags_unit_if #(
   parameter int WIDTH = 8
);
   logic [2:0]       alu_control;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] result;
   logic             c_out;
   logic             flag_we;
   logic             chain;
   logic             sticky_clr;
   logic             push;
   logic             pop;
   logic [3:0]       cond;
   logic             negative;
   logic             zero;
   logic             carry;
   logic             overflow;
   logic             sticky_v;
   logic             sticky_c;
   logic             cond_true;
   logic             stack_full;
   logic             stack_empty;
   logic             stack_err;

   modport master (
      output alu_control, a, b, sum, result, c_out,
      output flag_we, chain, sticky_clr, push, pop, cond,
      input  negative, zero, carry, overflow, sticky_v, sticky_c,
      input  cond_true, stack_full, stack_empty, stack_err
   );

   modport slave (
      input  alu_control, a, b, sum, result, c_out,
      input  flag_we, chain, sticky_clr, push, pop, cond,
      output negative, zero, carry, overflow, sticky_v, sticky_c,
      output cond_true, stack_full, stack_empty, stack_err
   );
endinterface

// File: rtl/status_flags_unit_flag_stack.sv
// LIFO used to save and restore NZCV context. A simultaneous push and pop
// cancel out; an overflowing push or underflowing pop is dropped and
// reported with a single-cycle err pulse.
module flag_stack
   import status_flags_unit_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int DW    = NZCV_W
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  logic [DW-1:0] push_data,
   output logic [DW-1:0] top_data,
   output logic          pop_ok,
   output logic          full,
   output logic          empty,
   output logic          err
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [CW-1:0] count;
   logic [CW-1:0] top_idx;
   logic [DW-1:0] mem [DEPTH];
   logic          push_ok;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign push_ok = push & ~pop & ~full;
   assign pop_ok  = pop & ~push & ~empty;
   assign top_idx = count - CW'(1);
   assign top_data = empty ? '0 : mem[top_idx[IW-1:0]];

   // Storage and pointer; reset wipes saved entries along with the pointer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (push_ok) begin
         mem[count[IW-1:0]] <= push_data;
         count <= count + CW'(1);
      end else if (pop_ok) begin
         count <= count - CW'(1);
      end
   end

   // Error pulse for a lone push on a full stack or lone pop on an empty one.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err <= 1'b0;
      end else begin
         err <= (push & ~pop & full) | (pop & ~push & empty);
      end
   end
endmodule

// File: rtl/status_flags_unit.sv
// Registered NZCV status unit: captures flags from the ALU on flag_we,
// accumulates Z across chained words, keeps sticky V/C, saves/restores
// flags through a small stack and evaluates a condition code.
module status_flags_unit
   import status_flags_unit_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int STACK_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   status_flags_unit_if.slave   bus
);
   localparam int MSB = WIDTH - 1;

   logic [NZCV_W-1:0] flags;
   logic [NZCV_W-1:0] next_flags;
   logic [NZCV_W-1:0] stack_top;
   logic              pop_ok;
   logic              res_zero;
   logic              cond_hit;
   logic              sticky_v_q;
   logic              sticky_c_q;
   logic              n, z, c, v;
   logic              unused_bits;

   assign n = flags[FLAG_N];
   assign z = flags[FLAG_Z];
   assign c = flags[FLAG_C];
   assign v = flags[FLAG_V];

   assign unused_bits = ^{bus.alu_control[2], bus.a[MSB-1:0],
                          bus.b[MSB-1:0], bus.sum[MSB-1:0]};

   // Candidate flags from the current ALU result; logic ops never carry or overflow.
   always_comb begin
      next_flags = '0;
      res_zero   = (bus.result == '0);
      next_flags[FLAG_N] = bus.result[MSB];
      next_flags[FLAG_Z] = bus.chain ? (z & res_zero) : res_zero;
      next_flags[FLAG_C] = ~bus.alu_control[1] & bus.c_out;
      next_flags[FLAG_V] = ~bus.alu_control[1]
                         & ~(bus.a[MSB] ^ bus.b[MSB] ^ bus.alu_control[0])
                         & (bus.a[MSB] ^ bus.sum[MSB]);
   end

   flag_stack #(
      .DEPTH (STACK_DEPTH),
      .DW    (NZCV_W)
   ) u_stack (
      .clk       (clk),
      .rst       (rst),
      .push      (bus.push),
      .pop       (bus.pop),
      .push_data (flags),
      .top_data  (stack_top),
      .pop_ok    (pop_ok),
      .full      (bus.stack_full),
      .empty     (bus.stack_empty),
      .err       (bus.stack_err)
   );

   // Live flags: a fresh ALU capture takes priority over a stack restore.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         flags <= '0;
      end else if (bus.flag_we) begin
         flags <= next_flags;
      end else if (pop_ok) begin
         flags <= stack_top;
      end
   end

   // Sticky V/C: a set in the same cycle as a clear survives.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sticky_v_q <= 1'b0;
         sticky_c_q <= 1'b0;
      end else begin
         sticky_v_q <= (sticky_v_q & ~bus.sticky_clr) | (bus.flag_we & next_flags[FLAG_V]);
         sticky_c_q <= (sticky_c_q & ~bus.sticky_clr) | (bus.flag_we & next_flags[FLAG_C]);
      end
   end

   // Condition-code evaluation against the registered flags.
   always_comb begin
      cond_hit = 1'b0;
      case (bus.cond)
         COND_EQ: cond_hit = z;
         COND_NE: cond_hit = ~z;
         COND_CS: cond_hit = c;
         COND_CC: cond_hit = ~c;
         COND_MI: cond_hit = n;
         COND_PL: cond_hit = ~n;
         COND_VS: cond_hit = v;
         COND_VC: cond_hit = ~v;
         COND_HI: cond_hit = c & ~z;
         COND_LS: cond_hit = ~c | z;
         COND_GE: cond_hit = (n == v);
         COND_LT: cond_hit = (n != v);
         COND_GT: cond_hit = ~z & (n == v);
         COND_LE: cond_hit = z | (n != v);
         COND_AL: cond_hit = 1'b1;
         default: cond_hit = 1'b0;
      endcase
   end

   assign bus.negative  = n;
   assign bus.zero      = z;
   assign bus.carry     = c;
   assign bus.overflow  = v;
   assign bus.sticky_v  = sticky_v_q;
   assign bus.sticky_c  = sticky_c_q;
   assign bus.cond_true = cond_hit;
endmodule

// File: tb/tb_status_flags_unit.sv
// Self-checking bench for status_flags_unit: directed steps from the test
// plan followed by randomized traffic, all compared against a behavioural
// model built from two's-complement arithmetic and a queue-based stack.
module tb_status_flags_unit;
   import status_flags_unit_pkg::*;

   localparam int WIDTH = 8;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   status_flags_unit_if #(.WIDTH(WIDTH)) bus ();

   status_flags_unit #(
      .WIDTH       (WIDTH),
      .STACK_DEPTH (DEPTH)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   bit       m_n, m_z, m_c, m_v, m_sv, m_sc, m_err;
   bit [3:0] m_stack[$];
   int       n_cmp = 0;
   int       n_err = 0;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit cond_model(input logic [3:0] cd);
      case (cd)
         4'd0:    return m_z;
         4'd1:    return !m_z;
         4'd2:    return m_c;
         4'd3:    return !m_c;
         4'd4:    return m_n;
         4'd5:    return !m_n;
         4'd6:    return m_v;
         4'd7:    return !m_v;
         4'd8:    return m_c && !m_z;
         4'd9:    return !m_c || m_z;
         4'd10:   return m_n == m_v;
         4'd11:   return m_n != m_v;
         4'd12:   return !m_z && (m_n == m_v);
         4'd13:   return m_z || (m_n != m_v);
         4'd14:   return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   task automatic reset_model();
      {m_n, m_z, m_c, m_v} = 4'b0;
      m_sv = 0;
      m_sc = 0;
      m_err = 0;
      m_stack.delete();
   endtask

   task automatic check_output(input string tag);
      check({tag, "_n"},     bus.negative,    m_n);
      check({tag, "_z"},     bus.zero,        m_z);
      check({tag, "_c"},     bus.carry,       m_c);
      check({tag, "_v"},     bus.overflow,    m_v);
      check({tag, "_sv"},    bus.sticky_v,    m_sv);
      check({tag, "_sc"},    bus.sticky_c,    m_sc);
      check({tag, "_cond"},  bus.cond_true,   cond_model(bus.cond));
      check({tag, "_full"},  bus.stack_full,  m_stack.size() == DEPTH);
      check({tag, "_empty"}, bus.stack_empty, m_stack.size() == 0);
      check({tag, "_err"},   bus.stack_err,   m_err);
   endtask

   // Drives one cycle of ALU output plus strobes, advances the model, checks.
   task automatic apply_stimulus(input string tag, input logic [2:0] op,
                                 input logic [7:0] av, input logic [7:0] bv,
                                 input bit we, input bit ch, input bit clr,
                                 input bit ps, input bit pp, input logic [3:0] cd);
      logic [8:0] wide;
      logic [7:0] res;
      int         sa, sb, exact;
      bit         arith, nn, nz, nc, nv;
      bit [3:0]   cur, entry;
      bit         do_pop;

      wide = {1'b0, av} + {1'b0, (op[0] ? ~bv : bv)} + {8'd0, op[0]};
      case (op)
         ALU_AND: res = av & bv;
         ALU_OR:  res = av | bv;
         ALU_SLT: res = ($signed(av) < $signed(bv)) ? 8'd1 : 8'd0;
         default: res = wide[7:0];
      endcase

      bus.alu_control = op;
      bus.a           = av;
      bus.b           = bv;
      bus.sum         = wide[7:0];
      bus.result      = res;
      bus.c_out       = wide[8];
      bus.flag_we     = we;
      bus.chain       = ch;
      bus.sticky_clr  = clr;
      bus.push        = ps;
      bus.pop         = pp;
      bus.cond        = cd;

      arith = (op == ALU_ADD) || (op == ALU_SUB) || (op == ALU_SLT);
      sa    = int'($signed(av));
      sb    = int'($signed(bv));
      exact = (op == ALU_ADD) ? sa + sb : sa - sb;
      nv    = arith && (exact > 127 || exact < -128);
      nc    = arith && wide[8];
      nn    = res[7];
      nz    = (res == 8'd0) && (ch ? m_z : 1'b1);
      cur   = {m_n, m_z, m_c, m_v};
      entry = 4'b0;
      do_pop = 0;

      @(posedge clk);
      #1;
      m_err = (ps && !pp && m_stack.size() == DEPTH) || (pp && !ps && m_stack.size() == 0);
      if (ps && !pp && m_stack.size() < DEPTH) m_stack.push_back(cur);
      if (pp && !ps && m_stack.size() > 0) begin
         entry = m_stack.pop_back();
         do_pop = 1;
      end
      if (we) {m_n, m_z, m_c, m_v} = {nn, nz, nc, nv};
      else if (do_pop) {m_n, m_z, m_c, m_v} = entry;
      m_sv = (m_sv && !clr) || (we && nv);
      m_sc = (m_sc && !clr) || (we && nc);
      check_output(tag);
   endtask

   task automatic idle(input string tag);
      apply_stimulus(tag, ALU_ADD, 8'h00, 8'h00, 0, 0, 0, 0, 0, 4'd0);
   endtask

   initial begin
      logic [2:0] ops [5];
      logic [3:0] got;
      ops = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT};

      // Reset state
      rst = 1'b1;
      bus.alu_control = '0; bus.a = '0; bus.b = '0; bus.sum = '0; bus.result = '0;
      bus.c_out = 0; bus.flag_we = 0; bus.chain = 0; bus.sticky_clr = 0;
      bus.push = 0; bus.pop = 0; bus.cond = 4'd0;
      reset_model();
      #12;
      check("rst_empty", bus.stack_empty, 1'b1);
      check("rst_full",  bus.stack_full,  1'b0);
      check_output("rst");
      @(negedge clk);
      rst = 1'b0;

      // Signed overflow on add
      apply_stimulus("add_ovf", ALU_ADD, 8'h7F, 8'h01, 1, 0, 0, 0, 0, COND_VS);
      check("add_ovf_nv", {bus.negative, bus.zero, bus.carry, bus.overflow}, 4'b1001);
      check("add_ovf_vs", bus.cond_true, 1'b1);
      check("add_ovf_stv", bus.sticky_v, 1'b1);

      // Equal subtract, then EQ/HI, then a logic op with carry-out ignored
      apply_stimulus("sub_eq", ALU_SUB, 8'h05, 8'h05, 1, 0, 0, 0, 0, COND_EQ);
      check("sub_eq_zcv", {bus.zero, bus.carry, bus.overflow}, 3'b110);
      check("sub_eq_eq", bus.cond_true, 1'b1);
      bus.cond = COND_HI;
      #1;
      check("sub_eq_hi", bus.cond_true, 1'b0);
      apply_stimulus("and_c", ALU_AND, 8'hFF, 8'h01, 1, 0, 0, 0, 0, COND_CS);
      check("and_c_carry", bus.carry, 1'b0);

      // Multi-word zero accumulation
      apply_stimulus("chain0", ALU_ADD, 8'h00, 8'h00, 1, 0, 0, 0, 0, COND_EQ);
      check("chain0_z", bus.zero, 1'b1);
      apply_stimulus("chain1", ALU_ADD, 8'h01, 8'h00, 1, 1, 0, 0, 0, COND_EQ);
      check("chain1_z", bus.zero, 1'b0);
      apply_stimulus("chain2", ALU_ADD, 8'h00, 8'h00, 1, 1, 0, 0, 0, COND_EQ);
      check("chain2_z", bus.zero, 1'b0);

      // Fill the stack with four distinct NZCV values
      apply_stimulus("set1", ALU_ADD, 8'h7F, 8'h01, 1, 0, 0, 0, 0, COND_AL);
      apply_stimulus("push1", ALU_ADD, 8'h00, 8'h00, 0, 0, 0, 1, 0, COND_AL);
      apply_stimulus("set2", ALU_SUB, 8'h05, 8'h05, 1, 0, 0, 0, 0, COND_AL);
      apply_stimulus("push2", ALU_ADD, 8'h00, 8'h00, 0, 0, 0, 1, 0, COND_AL);
      apply_stimulus("set3", ALU_ADD, 8'h80, 8'h80, 1, 0, 0, 0, 0, COND_AL);
      apply_stimulus("push3", ALU_ADD, 8'h00, 8'h00, 0, 0, 0, 1, 0, COND_AL);
      apply_stimulus("set4", ALU_OR, 8'h80, 8'h00, 1, 0, 0, 0, 0, COND_AL);
      apply_stimulus("push4", ALU_ADD, 8'h00, 8'h00, 0, 0, 0, 1, 0, COND_AL);
      check("push4_full", bus.stack_full, 1'b1);
      apply_stimulus("push5", ALU_ADD, 8'h00, 8'h00, 0, 0, 0, 1, 0, COND_AL);
      check("push5_err", bus.stack_err, 1'b1);
      idle("after_push5");
      check("after_push5_err", bus.stack_err, 1'b0);
      check("after_push5_full", bus.stack_full, 1'b1);

      // Drain in reverse order, then underflow
      apply_stimulus("pop1", ALU_ADD, 8'h00, 8'h00, 0, 0, 0, 0, 1, COND_AL);
      got = {bus.negative, bus.zero, bus.carry, bus.overflow};
      check("pop1_val", got, 4'b1000);
      apply_stimulus("pop2", ALU_ADD, 8'h00, 8'h00, 0, 0, 0, 0, 1, COND_AL);
      got = {bus.negative, bus.zero, bus.carry, bus.overflow};
      check("pop2_val", got, 4'b0111);
      apply_stimulus("pop3", ALU_ADD, 8'h00, 8'h00, 0, 0, 0, 0, 1, COND_AL);
      got = {bus.negative, bus.zero, bus.carry, bus.overflow};
      check("pop3_val", got, 4'b0110);
      apply_stimulus("pop4", ALU_ADD, 8'h00, 8'h00, 0, 0, 0, 0, 1, COND_AL);
      got = {bus.negative, bus.zero, bus.carry, bus.overflow};
      check("pop4_val", got, 4'b1001);
      apply_stimulus("pop5", ALU_ADD, 8'h00, 8'h00, 0, 0, 0, 0, 1, COND_AL);
      got = {bus.negative, bus.zero, bus.carry, bus.overflow};
      check("pop5_err", bus.stack_err, 1'b1);
      check("pop5_val", got, 4'b1001);

      // Push alongside a capture stores the pre-update flags
      apply_stimulus("push_we", ALU_SUB, 8'h05, 8'h05, 1, 0, 0, 1, 0, COND_AL);
      got = {bus.negative, bus.zero, bus.carry, bus.overflow};
      check("push_we_live", got, 4'b0110);
      apply_stimulus("pop_saved", ALU_ADD, 8'h00, 8'h00, 0, 0, 0, 0, 1, COND_AL);
      got = {bus.negative, bus.zero, bus.carry, bus.overflow};
      check("pop_saved_val", got, 4'b1001);

      // Simultaneous push and pop is a no-op
      apply_stimulus("push_one", ALU_ADD, 8'h00, 8'h00, 0, 0, 0, 1, 0, COND_AL);
      apply_stimulus("push_pop", ALU_ADD, 8'h00, 8'h00, 0, 0, 0, 1, 1, COND_AL);
      check("push_pop_err", bus.stack_err, 1'b0);
      check("push_pop_empty", bus.stack_empty, 1'b0);
      apply_stimulus("pop_last", ALU_ADD, 8'h00, 8'h00, 0, 0, 0, 0, 1, COND_AL);
      check("pop_last_empty", bus.stack_empty, 1'b1);

      // Sticky clear, and set-beats-clear
      apply_stimulus("stk_clr", ALU_ADD, 8'h00, 8'h00, 0, 0, 1, 0, 0, COND_AL);
      check("stk_clr_sv", bus.sticky_v, 1'b0);
      apply_stimulus("stk_set", ALU_ADD, 8'h7F, 8'h01, 1, 0, 1, 0, 0, COND_AL);
      check("stk_set_sv", bus.sticky_v, 1'b1);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         apply_stimulus("rnd", ops[$urandom_range(0, 4)], 8'($urandom), 8'($urandom),
                        $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 2,
                        $urandom_range(0, 9) < 1, $urandom_range(0, 99) < 18,
                        $urandom_range(0, 99) < 15, 4'($urandom));
      end

      // Asynchronous reset between clock edges
      apply_stimulus("pre_arst", ALU_ADD, 8'h7F, 8'h01, 1, 0, 0, 1, 0, COND_VS);
      #2;
      rst = 1'b1;
      #1;
      reset_model();
      check("arst_n", bus.negative, 1'b0);
      check("arst_sv", bus.sticky_v, 1'b0);
      check("arst_empty", bus.stack_empty, 1'b1);
      check_output("arst");
      #2;
      rst = 1'b0;
      idle("post_arst");
      apply_stimulus("post_arst_pop", ALU_ADD, 8'h00, 8'h00, 0, 0, 0, 0, 1, COND_AL);
      check("post_arst_pop_err", bus.stack_err, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/status_flags_unit.md
Name: status_flags_unit

Overview:
- Registered, width-parametrised NZCV status unit for the ALU datapath; the successor to the purely combinational flag logic.
- Captures flags on a write strobe and supports multi-precision chaining, where Z accumulates across words.
- Keeps sticky overflow/carry bits and a push/pop flag stack for context save.
- Evaluates a 4-bit condition code against the live flags so branch/predicate logic downstream does not re-decode them.

Parameters:
- WIDTH, 8, operand/result width in bits (≥2).
- STACK_DEPTH, 4, number of NZCV entries in the save stack (≥1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- alu_control  in  3  ALU op: 000 add, 001 sub, 010 and, 011 or, 101 slt.
- a  in  WIDTH  ALU operand A.
- b  in  WIDTH  ALU operand B (uninverted).
- sum  in  WIDTH  adder output.
- result  in  WIDTH  final ALU result.
- c_out  in  1  adder carry out.
- flag_we  in  1  capture new flags this cycle.
- chain  in  1  with flag_we: Z accumulates (multi-word op).
- sticky_clr  in  1  clear sticky_v/sticky_c.
- push  in  1  save current NZCV to stack.
- pop  in  1  restore NZCV from stack.
- cond  in  4  condition code to evaluate.
- negative, zero, carry, overflow  out  1 each  registered flags.
- sticky_v, sticky_c  out  1 each  OR-accumulated V and C since last clear.
- cond_true  out  1  cond satisfied by registered flags.
- stack_full, stack_empty  out  1 each  stack status.
- stack_err  out  1  one-cycle pulse on push-when-full or pop-when-empty.

Behaviour:
- Reset (async, active-high): all flags 0, sticky 0, stack pointer 0, stack_empty=1, stack_full=0, stack_err=0. cond_true follows from the reset flags.
- Next-flag computation (combinational, WIDTH-generic):
  - Nn = result[WIDTH-1].
  - Zn = (result==0); when chain=1, Zn = zero & (result==0).
  - Cn = ~alu_control[1] & c_out.
  - Vn = ~alu_control[1] & ~(a[MSB]^b[MSB]^alu_control[0]) & (a[MSB]^sum[MSB]).
- flag_we=1: N,Z,C,V load Nn,Zn,Cn,Vn at the next edge (1-cycle latency). flag_we=0: flags hold.
- Sticky bits:
  - On flag_we, sticky_v |= Vn and sticky_c |= Cn.
  - sticky_clr zeroes both.
  - sticky_clr together with a flag_we that sets the bit: set wins, so the event is never lost.
- Stack (LIFO of 4-bit NZCV):
  - push stores the currently registered flags, i.e. pre-update values if flag_we is active the same cycle.
  - pop loads the top entry into the flags.
  - pop together with flag_we: flag_we wins for the flags; the entry is still discarded.
  - push together with pop: the stack is unchanged, the flags are unchanged except by flag_we, and no error.
  - push when full or pop when empty: the operation is ignored and stack_err pulses high for exactly one cycle.
  - stack_full is high when count==STACK_DEPTH; stack_empty is high when count==0.
- Condition evaluation (combinational from registered flags):
  - 0 EQ Z; 1 NE ~Z; 2 CS C; 3 CC ~C.
  - 4 MI N; 5 PL ~N; 6 VS V; 7 VC ~V.
  - 8 HI C&~Z; 9 LS ~C|Z; 10 GE N==V; 11 LT N!=V.
  - 12 GT ~Z&(N==V); 13 LE Z|(N!=V); 14 AL 1; 15 NV 0.
- Reset asserted mid-operation clears the stack contents and pointer immediately; stacked entries are not preserved.

Decomposition:
- Shared package holds:
  - ALU op encodings (ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT).
  - Condition-code constants COND_EQ … COND_NV.
  - NZCV bit-index constants.
- One sub-module, flag_stack: parametrised LIFO carrying STACK_DEPTH×4 data with full/empty/err outputs.
- Flag computation and condition decode stay in status_flags_unit.

Test Plan:
- WIDTH=8, add a=0x7F, b=0x01, sum=result=0x80, c_out=0, flag_we=1 → next cycle N=1 Z=0 C=0 V=1; sticky_v=1; cond=6 (VS) gives cond_true=1.
- Sub a=0x05, b=0x05 (sum=result=0x00, c_out=1) → Z=1 C=1 V=0; cond=0 (EQ) gives 1, cond=8 (HI) gives 0; then an AND op with c_out=1 → C=0.
- Chained 16-bit zero test: word0 result=0x00 with chain=0, then word1 result=0x01 with chain=1 → Z=1 then Z=0; a chain=1 word following a nonzero word with result=0x00 keeps Z=0.
- Stack, STACK_DEPTH=4: push 4 distinct NZCV values → stack_full=1; a 5th push → stack_err pulses 1 cycle and the stack is unchanged; 4 pops restore the values in reverse order; a 5th pop → stack_err and the flags are unchanged.
- push with flag_we in the same cycle → the stacked entry equals the pre-update flags and the live flags equal the new values; push with pop → count unchanged, no stack_err.
- sticky_clr with an overflowing flag_we in the same cycle → sticky_v=1; rst asserted asynchronously mid-sequence → all outputs at reset values before the next clock edge.
